// File: rtl/ipm2t_hssthp_wtchdg_pkg.sv
// ipm2t_hssthp_wtchdg_pkg
// Shared definitions for the multi-channel HSSTHP reset watchdog:
//   - wtchdg_st_e : 2-bit per-channel state encoding, visible on wtchdg_st
//   - cnt_width() : counter width for a given terminal value
package ipm2t_hssthp_wtchdg_pkg;

  typedef enum logic [1:0] {
    WTCHDG_WAIT  = 2'b00,
    WTCHDG_COUNT = 2'b01,
    WTCHDG_ALARM = 2'b10,
    WTCHDG_FAIL  = 2'b11
  } wtchdg_st_e;

  // One spare bit above $clog2 so the terminal value itself always fits.
  function automatic int cnt_width(input int terminal);
    return $clog2(terminal) + 1;
  endfunction

endpackage

// File: rtl/ipm2t_hssthp_rst_wtchdg_ch.sv
// ipm2t_hssthp_rst_wtchdg_ch
// One watchdog channel: WAIT -> COUNT -> ALARM (reset pulse) -> WAIT/COUNT,
// with an optional bounded retry count that parks the channel in FAIL.
// Optional feature macro: IPM2T_HSSTHP_WTCHDG_RETRY_EN (retry counter + FAIL).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            synchronous clear, overrides every FSM rule
//   wtchdg_in      health input (polarity set by OK_ACTIVE_HIGH)
//   tick           shared prescaler tick
//   wtchdg_rst_n   registered reset request, active low
//   wtchdg_st      registered state
//   wtchdg_fail    registered sticky failure flag
module ipm2t_hssthp_rst_wtchdg_ch
  import ipm2t_hssthp_wtchdg_pkg::*;
#(
  parameter int OK_ACTIVE_HIGH = 1,
  parameter int TIMEOUT_TICKS  = 512,
  parameter int RST_CYCLES     = 512,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wtchdg_in,
  input  logic       tick,
  output logic       wtchdg_rst_n,
  output wtchdg_st_e wtchdg_st,
  output logic       wtchdg_fail
);

  if (TIMEOUT_TICKS < 1 || RST_CYCLES < 1 || MAX_RETRY < 1) begin : g_bad_param
    $error("ipm2t_hssthp_rst_wtchdg_ch: TIMEOUT_TICKS, RST_CYCLES and MAX_RETRY must be >= 1");
  end

  localparam int TICK_W = cnt_width(TIMEOUT_TICKS);
  localparam int RST_W  = cnt_width(RST_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIMEOUT_TICKS - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);

  logic              ok;
  logic              retry_done;
  wtchdg_st_e        st_nxt;
  logic [TICK_W-1:0] tick_cnt, tick_nxt;
  logic [RST_W-1:0]  rst_cnt, rst_nxt;

  assign ok = (wtchdg_in == (OK_ACTIVE_HIGH != 0));

`ifdef IPM2T_HSSTHP_WTCHDG_RETRY_EN
  localparam int RETRY_W = cnt_width(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0] retry_cnt, retry_nxt;

  assign retry_done = (retry_cnt == RETRY_LAST);
`else
  assign retry_done = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can
    // leave it unassigned and infer a latch.
    st_nxt   = wtchdg_st;
    tick_nxt = tick_cnt;
    rst_nxt  = rst_cnt;
`ifdef IPM2T_HSSTHP_WTCHDG_RETRY_EN
    retry_nxt = retry_cnt;
`endif
    if (clr) begin
      st_nxt   = WTCHDG_WAIT;
      tick_nxt = '0;
      rst_nxt  = '0;
`ifdef IPM2T_HSSTHP_WTCHDG_RETRY_EN
      retry_nxt = '0;
`endif
    end else begin
      case (wtchdg_st)
        WTCHDG_WAIT: begin
          if (!ok) begin
            st_nxt   = WTCHDG_COUNT;
            tick_nxt = '0;
          end
        end
        WTCHDG_COUNT: begin
          if (ok) begin
            // A healthy interval restores the full retry budget.
            st_nxt = WTCHDG_WAIT;
`ifdef IPM2T_HSSTHP_WTCHDG_RETRY_EN
            retry_nxt = '0;
`endif
          end else if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              st_nxt  = WTCHDG_ALARM;
              rst_nxt = '0;
`ifdef IPM2T_HSSTHP_WTCHDG_RETRY_EN
              retry_nxt = retry_cnt + RETRY_W'(1);
`endif
            end else begin
              tick_nxt = tick_cnt + TICK_W'(1);
            end
          end
        end
        WTCHDG_ALARM: begin
          // ok is ignored here: a started pulse always runs its full length.
          if (rst_cnt == RST_LAST) begin
            if (retry_done) begin
              st_nxt = WTCHDG_FAIL;
            end else if (ok) begin
              st_nxt = WTCHDG_WAIT;
            end else begin
              st_nxt   = WTCHDG_COUNT;
              tick_nxt = '0;
            end
          end else begin
            rst_nxt = rst_cnt + RST_W'(1);
          end
        end
        default: begin
`ifdef IPM2T_HSSTHP_WTCHDG_RETRY_EN
          st_nxt = WTCHDG_FAIL;
`else
          st_nxt = WTCHDG_WAIT;
`endif
        end
      endcase
    end
  end

  // Outputs are registered from the next-state value so they line up with
  // the state register in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wtchdg_st    <= WTCHDG_WAIT;
      tick_cnt     <= '0;
      rst_cnt      <= '0;
      wtchdg_rst_n <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      wtchdg_st    <= st_nxt;
      tick_cnt     <= tick_nxt;
      rst_cnt      <= rst_nxt;
      wtchdg_rst_n <= (st_nxt != WTCHDG_ALARM);
    end
  end

`ifdef IPM2T_HSSTHP_WTCHDG_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt   <= '0;
      wtchdg_fail <= 1'b0;
    end else begin
      retry_cnt   <= retry_nxt;
      wtchdg_fail <= (st_nxt == WTCHDG_FAIL);
    end
  end
`else
  assign wtchdg_fail = 1'b0;
`endif

endmodule

// File: rtl/ipm2t_hssthp_rst_wtchdg_mc.sv
// ipm2t_hssthp_rst_wtchdg_mc
// Multi-channel watchdog for the HSSTHP reset sequencer. Holds the shared
// prescaler and the any-fail aggregate; one ipm2t_hssthp_rst_wtchdg_ch per lane.
// Optional feature macro: IPM2T_HSSTHP_WTCHDG_RETRY_EN (retry limit + FAIL).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wtchdg_clr        per-channel synchronous clear
//   wtchdg_in         per-channel health input
//   wtchdg_rst_n      per-channel reset request, active low, registered
//   wtchdg_st         per-channel state, bits [2i+1:2i] for channel i
//   wtchdg_fail       per-channel sticky failure flag
//   wtchdg_any_fail   registered OR of wtchdg_fail (one cycle behind it)
module ipm2t_hssthp_rst_wtchdg_mc
  import ipm2t_hssthp_wtchdg_pkg::*;
#(
  parameter int CH_NUM         = 4,
  parameter int OK_ACTIVE_HIGH = 1,
  parameter int PRESCALE_WIDTH = 9,
  parameter int TIMEOUT_TICKS  = 512,
  parameter int RST_CYCLES     = 512,
  parameter int MAX_RETRY      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH_NUM-1:0]   wtchdg_clr,
  input  logic [CH_NUM-1:0]   wtchdg_in,
  output logic [CH_NUM-1:0]   wtchdg_rst_n,
  output logic [2*CH_NUM-1:0] wtchdg_st,
  output logic [CH_NUM-1:0]   wtchdg_fail,
  output logic                wtchdg_any_fail
);

  if (CH_NUM < 1 || CH_NUM > 16) begin : g_bad_ch_num
    $error("ipm2t_hssthp_rst_wtchdg_mc: CH_NUM must be in 1..16");
  end

  logic [PRESCALE_WIDTH-1:0] presc;
  logic                      tick;

  // Free-running; channel events never disturb it, so timeout latency
  // depends on the prescaler phase when a channel starts counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESCALE_WIDTH'(1);
    end
  end

  assign tick = &presc;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    wtchdg_st_e st_i;

    ipm2t_hssthp_rst_wtchdg_ch #(
      .OK_ACTIVE_HIGH (OK_ACTIVE_HIGH),
      .TIMEOUT_TICKS  (TIMEOUT_TICKS),
      .RST_CYCLES     (RST_CYCLES),
      .MAX_RETRY      (MAX_RETRY)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (wtchdg_clr[i]),
      .wtchdg_in    (wtchdg_in[i]),
      .tick         (tick),
      .wtchdg_rst_n (wtchdg_rst_n[i]),
      .wtchdg_st    (st_i),
      .wtchdg_fail  (wtchdg_fail[i])
    );

    assign wtchdg_st[2*i +: 2] = st_i;
  end

`ifdef IPM2T_HSSTHP_WTCHDG_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wtchdg_any_fail <= 1'b0;
    end else begin
      wtchdg_any_fail <= |wtchdg_fail;
    end
  end
`else
  assign wtchdg_any_fail = 1'b0;
`endif

endmodule

// File: tb/tb_ipm2t_hssthp_rst_wtchdg_mc.sv
// tb_ipm2t_hssthp_rst_wtchdg_mc
// Directed bench: CH_NUM=2, P=4, TIMEOUT_TICKS=3, RST_CYCLES=5, MAX_RETRY=2.
// Edge numbers in the comments count rising edges after rst_n release, with
// the prescaler at 0 on release, so ticks are sampled on edges 4, 8, 12, ...
module tb_ipm2t_hssthp_rst_wtchdg_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] wtchdg_clr;
  logic [1:0] wtchdg_in;
  logic [1:0] wtchdg_rst_n;
  logic [3:0] wtchdg_st;
  logic [1:0] wtchdg_fail;
  logic       wtchdg_any_fail;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ipm2t_hssthp_rst_wtchdg_mc #(
    .CH_NUM         (2),
    .OK_ACTIVE_HIGH (1),
    .PRESCALE_WIDTH (2),
    .TIMEOUT_TICKS  (3),
    .RST_CYCLES     (5),
    .MAX_RETRY      (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wtchdg_clr      (wtchdg_clr),
    .wtchdg_in       (wtchdg_in),
    .wtchdg_rst_n    (wtchdg_rst_n),
    .wtchdg_st       (wtchdg_st),
    .wtchdg_fail     (wtchdg_fail),
    .wtchdg_any_fail (wtchdg_any_fail)
  );

  // One vector row: drive in/clr, then expect the same outputs after each of
  // the next `cycles` rising edges.
  typedef struct {
    int         cycles;
    logic [1:0] in;
    logic [1:0] clr;
    logic [3:0] st;
    logic [1:0] rst_n;
    logic [1:0] fail;
    logic       any;
  } vec_t;

  vec_t seq[$];

  localparam logic [8:0] RESET_OUTS = {1'b0, 2'b00, 2'b11, 4'b0000};

  // Output bundle: {any_fail, fail[1:0], rst_n[1:0], st[3:0]}
  function automatic logic [8:0] outs();
    return {wtchdg_any_fail, wtchdg_fail, wtchdg_rst_n, wtchdg_st};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {any,fail,rst_n,st}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    wtchdg_in  = 2'b11;
    wtchdg_clr = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset values", outs(), RESET_OUTS);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int cycles, input string name, input logic [8:0] exp);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s cycle %0d", name, c), outs(), exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Timeout, recovery (retry budget restored), exhaustion and FAIL exit.
    // ch1 stays healthy throughout and must remain idle.
    seq.push_back('{11, 2'b10, 2'b00, 4'b0001, 2'b11, 2'b00, 1'b0}); // e1-11 COUNT
    seq.push_back('{ 5, 2'b10, 2'b00, 4'b0010, 2'b10, 2'b00, 1'b0}); // e12-16 pulse 1
    seq.push_back('{ 1, 2'b10, 2'b00, 4'b0001, 2'b11, 2'b00, 1'b0}); // e17 COUNT
    seq.push_back('{ 2, 2'b11, 2'b00, 4'b0000, 2'b11, 2'b00, 1'b0}); // e18-19 WAIT, retry=0
    seq.push_back('{12, 2'b10, 2'b00, 4'b0001, 2'b11, 2'b00, 1'b0}); // e20-31 COUNT
    seq.push_back('{ 5, 2'b10, 2'b00, 4'b0010, 2'b10, 2'b00, 1'b0}); // e32-36 pulse
    seq.push_back('{11, 2'b10, 2'b00, 4'b0001, 2'b11, 2'b00, 1'b0}); // e37-47 COUNT
    seq.push_back('{ 5, 2'b10, 2'b00, 4'b0010, 2'b10, 2'b00, 1'b0}); // e48-52 pulse
`ifdef IPM2T_HSSTHP_WTCHDG_RETRY_EN
    seq.push_back('{ 1, 2'b10, 2'b00, 4'b0011, 2'b11, 2'b01, 1'b0}); // e53 FAIL
    seq.push_back('{ 6, 2'b10, 2'b00, 4'b0011, 2'b11, 2'b01, 1'b1}); // e54-59 any_fail lags
    seq.push_back('{ 3, 2'b11, 2'b00, 4'b0011, 2'b11, 2'b01, 1'b1}); // e60-62 ok ignored
    seq.push_back('{ 1, 2'b11, 2'b01, 4'b0000, 2'b11, 2'b00, 1'b1}); // e63 clr
    seq.push_back('{ 2, 2'b11, 2'b00, 4'b0000, 2'b11, 2'b00, 1'b0}); // e64-65
`else
    seq.push_back('{11, 2'b10, 2'b00, 4'b0001, 2'b11, 2'b00, 1'b0}); // e53-63 COUNT
    seq.push_back('{ 5, 2'b10, 2'b00, 4'b0010, 2'b10, 2'b00, 1'b0}); // e64-68 pulse repeats
    seq.push_back('{ 1, 2'b10, 2'b00, 4'b0001, 2'b11, 2'b00, 1'b0}); // e69 COUNT
`endif

    do_reset();
    foreach (seq[r]) begin
      wtchdg_in  = seq[r].in;
      wtchdg_clr = seq[r].clr;
      for (int c = 0; c < seq[r].cycles; c++) begin
        @(posedge clk);
        #1;
        check($sformatf("seq row %0d cycle %0d", r, c), outs(),
              {seq[r].any, seq[r].fail, seq[r].rst_n, seq[r].st});
      end
    end

    // Clear on the 2nd pulse cycle: released next cycle, recounts after that.
    do_reset();
    wtchdg_in = 2'b10;
    run(11, "clr pre-count", {1'b0, 2'b00, 2'b11, 4'b0001});
    run(2,  "clr pulse",     {1'b0, 2'b00, 2'b10, 4'b0010});
    wtchdg_clr = 2'b01;
    run(1,  "clr release",   {1'b0, 2'b00, 2'b11, 4'b0000});
    wtchdg_clr = 2'b00;
    run(1,  "clr recount",   {1'b0, 2'b00, 2'b11, 4'b0001});

    // ch1 times out on its own while ch0 stays idle.
    do_reset();
    wtchdg_in = 2'b01;
    run(11, "ch1 count", {1'b0, 2'b00, 2'b11, 4'b0100});
    run(5,  "ch1 pulse", {1'b0, 2'b00, 2'b01, 4'b1000});
    run(1,  "ch1 after", {1'b0, 2'b00, 2'b11, 4'b0100});

    // Asynchronous reset in the middle of a pulse releases it immediately.
    do_reset();
    wtchdg_in = 2'b10;
    run(11, "async pre-count", {1'b0, 2'b00, 2'b11, 4'b0001});
    run(2,  "async pulse",     {1'b0, 2'b00, 2'b10, 4'b0010});
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset mid-pulse", outs(), RESET_OUTS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
